// File: rtl/dff_share_arb_pkg.sv
// dff_share_pkg: shared types and helpers for the dff_share_arb slice.
//   state_t  : arbiter FSM encoding (ST_IDLE, ST_OWN)
//   pick_t   : result of a round-robin pick (found flag + index)
//   clog2    : elaboration-time ceiling log2, used to size index fields
//   rr_pick  : loop-form round-robin pick for up to MAX_N requesters;
//              a reference form of what rr_pick_n computes structurally
package dff_share_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam int MAX_N = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } pick_t;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      for (int i = 0; i < 32; i++) begin
         if (x > 0) begin
            r++;
            x = x >> 1;
         end
      end
      return r;
   endfunction

   // First set bit of req[n-1:0] searching ptr+1, ptr+2, ... modulo n.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
      pick_t p;
      p = '0;
      for (int k = n; k >= 1; k--) begin
         int j;
         j = (ptr + k) % n;
         if (req[j]) begin
            p.found = 1'b1;
            p.idx   = 3'(j);
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/dff_share_arb_if.sv
// dff_share_arb_if: bus between the producers and the shared-register arbiter.
//   req, lock, d : from producers (requester i uses bit i / d[i*W +: W])
//   gnt          : one-hot grant back to producers (combinational)
//   q, q_src     : shared register and index of its last writer
//   q_vld        : register written at least once since reset
//   wr_cnt       : saturating write counter
//   state, owner : FSM state and current owner, exported for observation
// Handshake: requester i holds req[i] (and d) until it sees gnt[i]; the write
// commits on the rising edge where req[i] & gnt[i]. There is no back-pressure
// beyond gnt.
interface dff_share_arb_if #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = 16
);
   import dff_share_pkg::*;

   localparam int IW = clog2(N);

   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] d;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic [IW-1:0]  q_src;
   logic           q_vld;
   logic [CW-1:0]  wr_cnt;
   state_t         state;
   logic [IW-1:0]  owner;

   modport master (
      output req, lock, d,
      input  gnt, q, q_src, q_vld, wr_cnt, state, owner
   );

   modport slave (
      input  req, lock, d,
      output gnt, q, q_src, q_vld, wr_cnt, state, owner
   );

endinterface

// File: rtl/dff_share_arb_rr_pick.sv
// rr_pick_n: combinational round-robin picker, N-generic.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1
//   found : at least one request is set
//   idx   : winning index (valid when found)
// Rotates req so ptr+1 sits at bit 0, priority-encodes, then unrotates.
module rr_pick_n #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [N-1:0]  rot;
   logic [IW-1:0] k_sel;

   always_comb begin
      rot   = '0;
      k_sel = '0;
      for (int k = 0; k < N; k++) begin
         rot[k] = req[(int'(ptr) + 1 + k) % N];
      end
      found = |rot;
      // Descending scan so the lowest rotated position wins.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) k_sel = IW'(k);
      end
      idx = IW'((int'(ptr) + 1 + int'(k_sel)) % N);
   end

endmodule

// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin write arbiter for one shared W-bit register.
//   c     : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : dff_share_arb_if slave side (req/lock/d in, gnt/q/q_src/q_vld/
//           wr_cnt/state/owner out)
// IDLE picks round-robin after ptr; a winner with lock set takes ownership
// (OWN) and is granted every cycle it requests, until it requests without
// lock (final write) or drops its request (no write).
module dff_share_arb
   import dff_share_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int CW = 16
) (
   input logic           c,
   input logic           rst_n,
   dff_share_arb_if.slave bus
);

   localparam int IW = clog2(N);

   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] owner;
   logic [W-1:0]  q_r;
   logic [IW-1:0] q_src_r;
   logic          q_vld_r;
   logic [CW-1:0] wr_cnt_r;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [N-1:0]  gnt;

   rr_pick_n #(.N(N), .IW(IW)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant selection; held off entirely while reset is asserted.
   always_comb begin
      wr_en  = 1'b0;
      wr_idx = pick_idx;
      gnt    = '0;
      if (rst_n) begin
         if (state == ST_OWN) begin
            wr_idx = owner;
            wr_en  = bus.req[owner];
         end else begin
            wr_en  = pick_found;
         end
      end
      if (wr_en) gnt[wr_idx] = 1'b1;
   end

   always_ff @(posedge c) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= IW'(N - 1);
         owner    <= '0;
         q_r      <= '0;
         q_src_r  <= '0;
         q_vld_r  <= 1'b0;
         wr_cnt_r <= '0;
      end else begin
         if (wr_en) begin
            q_r     <= bus.d[int'(wr_idx)*W +: W];
            q_src_r <= wr_idx;
            q_vld_r <= 1'b1;
            if (wr_cnt_r != '1) wr_cnt_r <= wr_cnt_r + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (wr_en) begin
                  ptr <= wr_idx;
                  if (bus.lock[wr_idx]) begin
                     state <= ST_OWN;
                     owner <= wr_idx;
                  end
               end
            end
            ST_OWN: begin
               // ptr already equals owner, so round-robin resumes after it.
               if (!bus.req[owner] || !bus.lock[owner]) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.gnt    = gnt;
   assign bus.q      = q_r;
   assign bus.q_src  = q_src_r;
   assign bus.q_vld  = q_vld_r;
   assign bus.wr_cnt = wr_cnt_r;
   assign bus.state  = state;
   assign bus.owner  = owner;

endmodule

// File: tb/tb_dff_share_arb.sv
module tb_dff_share_arb;
   import dff_share_pkg::*;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int CW  = 16;
   localparam int CWS = 4;

   // ---------------- clock / reset ----------------
   logic c = 1'b0;
   logic rst_n = 1'b0;
   always #5 c = ~c;

   dff_share_arb_if #(.N(N), .W(W), .CW(CW))  bus ();
   dff_share_arb_if #(.N(N), .W(W), .CW(CWS)) bus_s ();

   assign bus_s.req  = bus.req;
   assign bus_s.lock = bus.lock;
   assign bus_s.d    = bus.d;

   dff_share_arb #(.N(N), .W(W), .CW(CW)) dut (
      .c(c), .rst_n(rst_n), .bus(bus)
   );

   dff_share_arb #(.N(N), .W(W), .CW(CWS)) dut_s (
      .c(c), .rst_n(rst_n), .bus(bus_s)
   );

   // ---------------- reference model / scoreboard ----------------
   int           n_cmp = 0;
   int           n_err = 0;
   int           m_last, m_owner, m_src, m_cnt, m_cnt_s;
   bit           m_own, m_vld;
   logic [W-1:0] m_q;
   logic [W-1:0] exp_q[$];
   logic [N-1:0] obs_gnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last = N - 1; m_owner = 0; m_own = 0;
      m_q = '0; m_src = 0; m_vld = 0; m_cnt = 0; m_cnt_s = 0;
      exp_q.delete();
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
   task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N*W-1:0] dd, input logic rs);
      logic [N-1:0] g;
      int win;
      bus.req = r; bus.lock = l; bus.d = dd; rst_n = rs;
      g = '0;
      win = -1;
      if (rs) begin
         if (m_own) begin
            if (r[m_owner]) win = m_owner;
         end else begin
            for (int k = 1; k <= N; k++) begin
               int j;
               j = (m_last + k) % N;
               if (win < 0 && r[j]) win = j;
            end
         end
      end
      if (win >= 0) g[win] = 1'b1;
      #4;
      obs_gnt = bus.gnt;
      check("gnt", 32'(bus.gnt), 32'(g));
      check("gnt_s", 32'(bus_s.gnt), 32'(g));
      @(posedge c); #1;
      if (!rs) begin
         model_reset();
      end else if (win >= 0) begin
         exp_q.push_back(dd[win*W +: W]);
         m_src = win;
         m_vld = 1;
         if (m_cnt < 2**CW - 1) m_cnt++;
         if (m_cnt_s < 2**CWS - 1) m_cnt_s++;
         if (m_own) begin
            if (!l[win]) m_own = 0;
         end else begin
            m_last = win;
            if (l[win]) begin
               m_own = 1;
               m_owner = win;
            end
         end
      end else begin
         m_own = 0;
      end
      if (exp_q.size() > 0) m_q = exp_q.pop_front();
      check("q", 32'(bus.q), 32'(m_q));
      check("q_src", 32'(bus.q_src), 32'(m_src));
      check("q_vld", 32'(bus.q_vld), 32'(m_vld));
      check("wr_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
      check("wr_cnt_sat", 32'(bus_s.wr_cnt), 32'(m_cnt_s));
      check("state", 32'(bus.state), 32'(m_own ? ST_OWN : ST_IDLE));
   endtask

   task automatic rand_d(output logic [N*W-1:0] dd);
      for (int i = 0; i < N; i++) dd[i*W +: W] = W'($urandom_range(0, 255));
   endtask

   // ---------------- stimulus ----------------
   logic [N*W-1:0] dd;
   int seq_a[6] = '{0, 1, 1, 1, 1, 0};

   initial begin
      bus.req = '0; bus.lock = '0; bus.d = '0;
      model_reset();
      @(posedge c); #1;

      // reset then idle
      step('0, '0, '0, 1'b0);
      step('0, '0, '0, 1'b0);
      step('0, '0, '0, 1'b1);
      check("idle_q", 32'(bus.q), 32'h0);
      check("idle_vld", 32'(bus.q_vld), 32'h0);
      check("idle_cnt", 32'(bus.wr_cnt), 32'h0);
      check("idle_gnt", 32'(obs_gnt), 32'h0);

      // single writer
      dd = '0;
      dd[2*W +: W] = 8'hA5;
      step(4'b0100, '0, dd, 1'b1);
      check("sw_gnt", 32'(obs_gnt), 32'h4);
      check("sw_q", 32'(bus.q), 32'hA5);
      check("sw_src", 32'(bus.q_src), 32'h2);
      check("sw_vld", 32'(bus.q_vld), 32'h1);
      check("sw_cnt", 32'(bus.wr_cnt), 32'h1);

      // round-robin, no lock
      step('0, '0, '0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         rand_d(dd);
         step(4'b1111, '0, dd, 1'b1);
         check("rr_order", 32'(obs_gnt), 32'(1 << (k % 4)));
      end
      check("rr_cnt", 32'(bus.wr_cnt), 32'd8);

      // lock burst: 0, then requester 1 for 3 locked + 1 final, then 0
      step('0, '0, '0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         rand_d(dd);
         step(4'b0011, (k >= 1 && k <= 3) ? 4'b0010 : 4'b0000, dd, 1'b1);
         check("lock_seq", 32'(obs_gnt), 32'(1 << seq_a[k]));
      end

      // owner drops request
      step('0, '0, '0, 1'b0);
      rand_d(dd);
      step(4'b1000, 4'b1000, dd, 1'b1);
      check("own_state", 32'(bus.state), 32'(ST_OWN));
      check("own_q", 32'(bus.q), 32'(dd[3*W +: W]));
      rand_d(dd);
      step(4'b0001, '0, dd, 1'b1);
      check("drop_gnt", 32'(obs_gnt), 32'h0);
      check("drop_src", 32'(bus.q_src), 32'h3);
      step(4'b0001, '0, dd, 1'b1);
      check("drop_next", 32'(obs_gnt), 32'h1);

      // reset in the middle of a locked sequence
      rand_d(dd);
      step(4'b1000, 4'b1000, dd, 1'b1);
      step(4'b1000, 4'b1000, dd, 1'b0);
      check("rstlock_gnt", 32'(obs_gnt), 32'h0);
      check("rstlock_state", 32'(bus.state), 32'(ST_IDLE));
      check("rstlock_q", 32'(bus.q), 32'h0);

      // saturation of the narrow counter
      for (int k = 0; k < 20; k++) begin
         rand_d(dd);
         step(4'b0001, '0, dd, 1'b1);
      end
      check("sat_cnt4", 32'(bus_s.wr_cnt), 32'd15);
      check("sat_cnt16", 32'(bus.wr_cnt), 32'd20);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [N-1:0] r, l;
         r = N'($urandom_range(0, 15));
         l = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 15)) : '0;
         rand_d(dd);
         step(r, l, dd, ($urandom_range(0, 39) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
